// File: rtl/sb_io.sv
// sb_io: single-bit bidirectional pad cell.
// The output-enable, output-data and input paths can each be combinational
// or registered on clk. An optional weak pull-up holds the pad high when
// nothing drives it.
// Optional feature macro: SB_IO_CLOCK_ENABLE_EN adds the CLOCK_ENABLE port.
// With that port present, the cell registers update only on enabled edges.
module sb_io #(
  parameter logic [5:0] PIN_TYPE = 6'b1010_01,
  parameter bit         PULLUP   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  inout  wire  PACKAGE_PIN,
  input  logic OUTPUT_ENABLE,
  input  logic D_OUT_0,
  output logic D_IN_0
`ifdef SB_IO_CLOCK_ENABLE_EN
  ,
  input  logic CLOCK_ENABLE
`endif
);

  localparam logic [1:0] OE_MODE   = PIN_TYPE[5:4];
  localparam logic [1:0] DOUT_MODE = PIN_TYPE[3:2];
  localparam logic [1:0] DIN_MODE  = PIN_TYPE[1:0];

  logic load_en;
  logic oe_q;
  logic dout_q;
  logic din_q;
  logic drive;
  logic pad_val;

`ifdef SB_IO_CLOCK_ENABLE_EN
  assign load_en = CLOCK_ENABLE;
`else
  assign load_en = 1'b1;
`endif

  // Reset always wins and clears all three registers, even when the clock enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q   <= 1'b0;
      dout_q <= 1'b0;
      din_q  <= 1'b0;
    end else if (load_en) begin
      oe_q   <= OUTPUT_ENABLE;
      dout_q <= D_OUT_0;
      din_q  <= PACKAGE_PIN;
    end
  end

  // Decide whether the cell drives the pad and which value it drives.
  always_comb begin
    drive   = 1'b0;
    pad_val = dout_q;
    case (OE_MODE)
      2'b00:   drive = 1'b0;
      2'b01:   drive = 1'b1;
      2'b10:   drive = OUTPUT_ENABLE;
      default: drive = oe_q;
    endcase
    case (DOUT_MODE)
      2'b10:   pad_val = D_OUT_0;
      2'b11:   pad_val = ~D_OUT_0;
      default: pad_val = dout_q;
    endcase
  end

  // When not driving, release the pad so an external master or the pull-up can set it.
  assign PACKAGE_PIN = drive ? pad_val : 1'bz;

  // The input side sees the resolved pad, so a driving cell reads back its own output.
  assign D_IN_0 = DIN_MODE[0] ? PACKAGE_PIN : din_q;

  // The weak pull-up exists only when PULLUP is set. Any strong driver overrides it.
  generate
    if (PULLUP) begin : g_pullup
      pullup pu (PACKAGE_PIN);
    end
  endgenerate

endmodule

// File: tb/tb_sb_io.sv
// tb_sb_io: directed self-checking bench for sb_io.
// The bench instantiates the default cell, a 16-bit bus array, a cell with a pull-up,
// an inverting cell and a fully registered cell with a pull-up.
module tb_sb_io;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

`ifdef SB_IO_CLOCK_ENABLE_EN
  logic ce = 1'b1;
`endif

  // default cell with an external driver on its pad
  logic def_oe = 1'b0, def_d = 1'b0, def_ext_en = 1'b0, def_ext = 1'b0, def_din;
  wire  def_pad;
  assign def_pad = def_ext_en ? def_ext : 1'bz;

  // combinational cell with pull-up and an external driver
  logic pu_oe = 1'b0, pu_d = 1'b0, pu_ext_en = 1'b0, pu_ext = 1'b0, pu_din;
  wire  pu_pad;
  assign pu_pad = pu_ext_en ? pu_ext : 1'bz;

  // inverting output cell
  logic inv_oe = 1'b0, inv_d = 1'b0, inv_din;
  wire  inv_pad;

  // fully registered cell with pull-up so a released pad reads 1
  logic reg_oe = 1'b0, reg_d = 1'b0, reg_din;
  wire  reg_pad;

  // 16-bit shared bus
  logic [15:0] bus_oe = '0, bus_d = '0, bus_ext = '0, bus_din;
  logic        bus_ext_en = 1'b0;
  wire  [15:0] bus_pad;
  assign bus_pad = bus_ext_en ? bus_ext : 16'hzzzz;

  always #5 clk = ~clk;

  sb_io u_def (
    .clk(clk), .rst(rst), .PACKAGE_PIN(def_pad), .OUTPUT_ENABLE(def_oe),
    .D_OUT_0(def_d), .D_IN_0(def_din)
`ifdef SB_IO_CLOCK_ENABLE_EN
    , .CLOCK_ENABLE(ce)
`endif
  );

  sb_io #(.PIN_TYPE(6'b1010_01), .PULLUP(1'b1)) u_pu (
    .clk(clk), .rst(rst), .PACKAGE_PIN(pu_pad), .OUTPUT_ENABLE(pu_oe),
    .D_OUT_0(pu_d), .D_IN_0(pu_din)
`ifdef SB_IO_CLOCK_ENABLE_EN
    , .CLOCK_ENABLE(ce)
`endif
  );

  sb_io #(.PIN_TYPE(6'b1011_01), .PULLUP(1'b0)) u_inv (
    .clk(clk), .rst(rst), .PACKAGE_PIN(inv_pad), .OUTPUT_ENABLE(inv_oe),
    .D_OUT_0(inv_d), .D_IN_0(inv_din)
`ifdef SB_IO_CLOCK_ENABLE_EN
    , .CLOCK_ENABLE(ce)
`endif
  );

  sb_io #(.PIN_TYPE(6'b1101_00), .PULLUP(1'b1)) u_reg (
    .clk(clk), .rst(rst), .PACKAGE_PIN(reg_pad), .OUTPUT_ENABLE(reg_oe),
    .D_OUT_0(reg_d), .D_IN_0(reg_din)
`ifdef SB_IO_CLOCK_ENABLE_EN
    , .CLOCK_ENABLE(ce)
`endif
  );

  for (genvar i = 0; i < 16; i++) begin : g_bus
    sb_io u_bit (
      .clk(clk), .rst(rst), .PACKAGE_PIN(bus_pad[i]), .OUTPUT_ENABLE(bus_oe[i]),
      .D_OUT_0(bus_d[i]), .D_IN_0(bus_din[i])
`ifdef SB_IO_CLOCK_ENABLE_EN
      , .CLOCK_ENABLE(ce)
`endif
    );
  end

  // one comparison: count it, and report tag/observed/expected on a miss
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // drive the registered cell's inputs
  task automatic applyStimulus(input logic oe, input logic d);
    reg_oe = oe;
    reg_d  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset: registered cell releases the pad and clears its input register
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    def_oe = 1'b1; def_d = 1'b1;
    tick();
    checkOutput("reg_rst_din", {15'd0, reg_din}, 16'h0000);
    checkOutput("reg_rst_pad", {15'd0, reg_pad}, 16'h0001);
    checkOutput("def_comb_in_rst_pad", {15'd0, def_pad}, 16'h0001);
    checkOutput("def_comb_in_rst_din", {15'd0, def_din}, 16'h0001);
    rst = 1'b0;

    // default cell: drive, external drive, loopback
    def_oe = 1'b1; def_d = 1'b1; #1;
    checkOutput("def_drive1_pad", {15'd0, def_pad}, 16'h0001);
    checkOutput("def_drive1_din", {15'd0, def_din}, 16'h0001);
    def_oe = 1'b0; def_ext_en = 1'b1; def_ext = 1'b0; #1;
    checkOutput("def_ext0_pad", {15'd0, def_pad}, 16'h0000);
    checkOutput("def_ext0_din", {15'd0, def_din}, 16'h0000);
    def_ext_en = 1'b0; def_oe = 1'b1; def_d = 1'b0; #1;
    checkOutput("def_loop0_din", {15'd0, def_din}, 16'h0000);

    // pull-up cell
    pu_oe = 1'b0; pu_ext_en = 1'b0; #1;
    checkOutput("pu_float_din", {15'd0, pu_din}, 16'h0001);
    pu_ext_en = 1'b1; pu_ext = 1'b0; #1;
    checkOutput("pu_ext0_din", {15'd0, pu_din}, 16'h0000);
    pu_ext_en = 1'b0; pu_oe = 1'b1; pu_d = 1'b0; #1;
    checkOutput("pu_drive0_din", {15'd0, pu_din}, 16'h0000);
    pu_oe = 1'b0; pu_d = 1'b1; #1;
    pu_oe = 1'b1; pu_d = 1'b1; #1;
    pu_oe = 1'b0; pu_d = 1'b0; #1;
    checkOutput("pu_oe_off_data_hidden", {15'd0, pu_pad}, 16'h0001);

    // inverted output
    inv_oe = 1'b1; inv_d = 1'b0; #1;
    checkOutput("inv_d0_pad", {15'd0, inv_pad}, 16'h0001);
    inv_d = 1'b1; #1;
    checkOutput("inv_d1_pad", {15'd0, inv_pad}, 16'h0000);
    checkOutput("inv_d1_din", {15'd0, inv_din}, 16'h0000);

    // bus: external master owns the bus, then the cells drive it
    bus_oe = 16'h0000; bus_d = 16'h5A3C; bus_ext_en = 1'b1; bus_ext = 16'hA5C3; #1;
    checkOutput("bus_ext_din", bus_din, 16'hA5C3);
    bus_ext_en = 1'b0; bus_oe = 16'hFFFF; bus_d = 16'h1234; #1;
    checkOutput("bus_drive_din", bus_din, 16'h1234);

    // registered cell: changes between edges stay invisible until the next edge
    applyStimulus(1'b1, 1'b0); #1;
    checkOutput("reg_before_edge_pad", {15'd0, reg_pad}, 16'h0001);
    tick();
    checkOutput("reg_e1_pad", {15'd0, reg_pad}, 16'h0000);
    checkOutput("reg_e1_din", {15'd0, reg_din}, 16'h0001);
    tick();
    checkOutput("reg_e2_din", {15'd0, reg_din}, 16'h0000);
    applyStimulus(1'b1, 1'b1); #1;
    checkOutput("reg_d1_before_edge_pad", {15'd0, reg_pad}, 16'h0000);
    tick();
    checkOutput("reg_d1_e1_pad", {15'd0, reg_pad}, 16'h0001);
    checkOutput("reg_d1_e1_din", {15'd0, reg_din}, 16'h0000);
    tick();
    checkOutput("reg_d1_e2_din", {15'd0, reg_din}, 16'h0001);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("reg_d0_pad", {15'd0, reg_pad}, 16'h0000);
    rst = 1'b1;
    tick();
    checkOutput("reg_rst_release_pad", {15'd0, reg_pad}, 16'h0001);
    checkOutput("reg_rst_clear_din", {15'd0, reg_din}, 16'h0000);
    rst = 1'b0;
    tick();
    checkOutput("reg_post_rst_pad", {15'd0, reg_pad}, 16'h0000);
    checkOutput("reg_post_rst_din", {15'd0, reg_din}, 16'h0001);

`ifdef SB_IO_CLOCK_ENABLE_EN
    // clock enable low: every register holds
    ce = 1'b0;
    applyStimulus(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("ce0_hold_pad", {15'd0, reg_pad}, 16'h0000);
      checkOutput("ce0_hold_din", {15'd0, reg_din}, 16'h0001);
    end
    ce = 1'b1;
    tick();
    checkOutput("ce1_pad", {15'd0, reg_pad}, 16'h0001);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("ce1_d0_pad", {15'd0, reg_pad}, 16'h0000);
    checkOutput("ce1_d0_din", {15'd0, reg_din}, 16'h0001);
    ce = 1'b0; rst = 1'b1;
    tick();
    checkOutput("ce0_rst_pad", {15'd0, reg_pad}, 16'h0001);
    checkOutput("ce0_rst_din", {15'd0, reg_din}, 16'h0000);
    rst = 1'b0; ce = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sb_io.md
# sb_io

Single-bit bidirectional I/O pad cell with a configurable tri-state output path, an input capture path and an optional weak pull-up. It sits between a package pin and fabric logic. It is instantiated as an array, one instance per bit, for shared bidirectional buses such as the 16-bit GPMC address/data bus. Output-enable, output-data and input paths are each independently selectable as combinational or registered on `clk`.

## Interface
- `PIN_TYPE`, default 6'b1010_01: path configuration.
  - [5:4] output-enable mode.
  - [3:2] output-data mode.
  - [1:0] input mode.
- `PULLUP`, default 1'b0: 1 enables a weak pull-up on the pin while it is not driven.
- `clk`  input  1  clock for all internal registers.
- `rst`  input  1  reset; synchronous and active-high.
- `PACKAGE_PIN`  inout  1  pad.
- `OUTPUT_ENABLE`  input  1  1 requests that the pad be driven.
- `D_OUT_0`  input  1  data to drive onto the pad.
- `D_IN_0`  output  1  data read from the pad.
- `CLOCK_ENABLE`  input  1  present only when `SB_IO_CLOCK_ENABLE_EN` is defined.

## Operation
- Output-enable mode, `PIN_TYPE[5:4]`:
  - 00: never drive.
  - 01: always drive.
  - 10: drive = `OUTPUT_ENABLE`, combinational.
  - 11: drive = `oe_q`, a register loaded from `OUTPUT_ENABLE`.
- Output-data mode, `PIN_TYPE[3:2]`:
  - 10: pad value = `D_OUT_0`, combinational.
  - 11: pad value = ~`D_OUT_0`, combinational.
  - 00 and 01: pad value = `dout_q`, a register loaded from `D_OUT_0`.
- Pad drive: `PACKAGE_PIN` = pad value while drive = 1; otherwise the pad is high-impedance.
- Pull-up: with `PULLUP`=1 and drive = 0, the pad resolves to a weak 1 that any external strong driver overrides. With `PULLUP`=0 an undriven pad reads z.
- Input mode, `PIN_TYPE[1:0]`:
  - 01 and 11: `D_IN_0` = `PACKAGE_PIN`, combinational.
  - 00 and 10: `D_IN_0` = `din_q`, a register loaded from `PACKAGE_PIN`.
- The input path always samples the resolved pad value. While driving, `D_IN_0` therefore reflects the cell's own output (loopback).
- Reset: `oe_q`=0, `dout_q`=0, `din_q`=0.
  - A registered-OE cell releases the pad on the first `clk` edge with `rst`=1.
  - In registered input mode `D_IN_0`=0 after reset.
  - `rst` has no effect on combinational paths.
- An illegal `PIN_TYPE` value does not exist; every encoding maps as above.

## Timing
- Combinational paths have zero-cycle latency: a change on `OUTPUT_ENABLE`, `D_OUT_0` or `PACKAGE_PIN` is visible in the same delta.
- Registered paths load on `posedge clk` and have one-cycle latency.
- `rst` takes priority over the clock enable when both are asserted on the same edge.
- Simultaneous OE deassert and data change in combinational modes: the pad goes to z; the data change is not observed on the pad.
- Deasserting `rst` mid-operation: registers load normally on the next enabled edge.

## Configuration
- `SB_IO_CLOCK_ENABLE_EN` defined:
  - The port `CLOCK_ENABLE` exists.
  - `oe_q`, `dout_q` and `din_q` update only on edges where `CLOCK_ENABLE`=1 and otherwise hold.
  - Reset is unaffected by `CLOCK_ENABLE`.
- `SB_IO_CLOCK_ENABLE_EN` not defined: the port is absent and the registers load on every edge.

## Test plan
- Default `PIN_TYPE` 1010_01:
  - `OUTPUT_ENABLE`=1, `D_OUT_0`=1 -> pad=1 and `D_IN_0`=1 immediately.
  - `OUTPUT_ENABLE`=0 with the external driver at 0 -> pad=0 and `D_IN_0`=0.
- Bus contention check: 16-instance array, external master drives 16'hA5C3 while `OUTPUT_ENABLE`=0 -> `D_IN_0` bus = 16'hA5C3, and the cell never drives the pad.
- `PIN_TYPE` 1101_00:
  - `OUTPUT_ENABLE`=1, `D_OUT_0`=1 asserted between edges -> pad stays z until the next edge, then 1; `D_IN_0` = 1 one edge after that.
  - `rst`=1 -> pad z and `D_IN_0`=0 after the edge.
- `PULLUP`=1 with no driver anywhere -> `D_IN_0`=1. An external 0 then overrides the pull-up -> `D_IN_0`=0.
- Inverted mode 1011_01, `OUTPUT_ENABLE`=1, `D_OUT_0`=0 -> pad=1.
- With `SB_IO_CLOCK_ENABLE_EN` defined and `PIN_TYPE` 1101_00:
  - `CLOCK_ENABLE`=0 while `D_OUT_0` toggles 0->1 -> pad holds its previous value across 3 edges.
  - `CLOCK_ENABLE`=1 -> pad=1 after one edge.
  - `rst`=1 with `CLOCK_ENABLE`=0 -> registers clear anyway.
